vcm_i2c_target: RTL and testbench
=================================

# vcm_i2c_target

I2C target (responder) that models the voice-coil-motor focus driver seen by the autofocus I2C master, running on the 50 MHz system clock. It decodes START/STOP, matches a 7-bit device address, accepts 2-byte focus-position writes into a 16-bit register, and returns that register on reads. It sits in the camera simulation and loopback path, closing the loop on the focus step controller without the physical D8M module.

## Interface
- DEV_ADDR, 7'h0C: 7-bit target address; write byte 0x18, read byte 0x19.
- FILT, 3: SCL/SDA glitch filter; a level must be stable for this many CLK_50 cycles to be accepted. Range 1-7.
- CLK_50  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SCL  in  1  I2C clock from master, asynchronous to CLK_50.
- SDA_IN  in  1  I2C data line as seen on the pad, asynchronous.
- SDA_OE  out  1  1 = pull SDA low (ACK or read-data 0); 0 = release. The pad is open-drain: SDA = SDA_OE ? 0 : 'z'.
- VCM_DATA  out  16  last committed focus word, {byte0, byte1}.
- STEP  out  10  VCM_DATA[13:4], the DAC position.
- DATA_VALID  out  1  one-cycle pulse when VCM_DATA is updated.
- BUSY  out  1  high from an accepted address match until STOP, or until a START that is not followed by a match.

## Operation
- Input conditioning: 2-flop synchronizer per line, then FILT-cycle stability filter, giving clean scl_f and sda_f.
- Events are derived from scl_f and sda_f:
  - START: sda_f falls while scl_f = 1.
  - STOP: sda_f rises while scl_f = 1.
  - scl_rise and scl_fall: edges of scl_f.
- FSM states:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits on scl_rise, MSB first.
  - ADDR_ACK: on a match, drive ACK; R/W=0 goes to WR_BYTE, R/W=1 goes to RD_BYTE. On a mismatch, release SDA and return to IDLE.
  - WR_BYTE: shifts 8 bits.
  - WR_ACK: ACK the byte.
  - RD_BYTE: drive 8 bits.
  - RD_ACK: sample the master's ACK/NACK.
- Write path:
  - Byte index 0 loads shadow[15:8]; index 1 loads shadow[7:0].
  - Both bytes are ACKed.
  - On the scl_fall that ends the ACK of byte 1: VCM_DATA <= shadow and DATA_VALID pulses.
  - Byte index ≥2 is NACKed (SDA released) and ignored.
- Read path:
  - Index 0 returns VCM_DATA[15:8]; index 1 returns VCM_DATA[7:0].
  - Master ACK continues to the next byte; the index wraps 1→0.
  - Master NACK goes to IDLE, with SDA released.
- START in any state: abort the current transfer and go to ADDR with index = 0 (repeated START).
- STOP in any state: go to IDLE, SDA_OE <= 0, BUSY <= 0. If only byte 0 was written, the shadow is discarded and VCM_DATA is unchanged.
- Reset values: SDA_OE=0, VCM_DATA=16'h0000, STEP=0, DATA_VALID=0, BUSY=0, FSM=IDLE, index=0.
- RESET asserted mid-transfer: SDA_OE releases asynchronously and immediately; the transfer is lost.

## Timing
- Event detect latency: 2 (sync) + FILT (filter) CLK_50 cycles after the pad edge, 5 cycles at defaults.
- SDA_OE changes only on detected scl_fall, one cycle after it, and never while scl_f = 1. This guarantees data hold relative to the master's SCL.
- ACK: SDA_OE rises one cycle after the scl_fall following bit 8 and drops one cycle after the next scl_fall.
- Data is sampled on scl_rise.
- DATA_VALID is high for exactly one CLK_50 cycle. VCM_DATA and STEP update in that same cycle.
- Minimum SCL high/low time: FILT+3 cycles. 400 kHz I2C is supported with wide margin.

## Structure
- Shared package vcm_i2c_pkg holds:
  - the state enum;
  - VCM_ADDR_DEFAULT = 7'h0C;
  - the STEP slice positions (13:4).
  The same package is used by the master-side focus controller.
- One sub-module, i2c_line_filter (synchronizer + FILT filter, one instance per line). It is reusable for the master side.

## Test plan
- Write 0x18, 0x3F, 0xF0, STOP → three ACKs; VCM_DATA=16'h3FF0, STEP=10'h3FF, one DATA_VALID pulse.
- Address 0x1A (wrong address) then two bytes → no ACK on any bit; VCM_DATA unchanged; BUSY stays 0.
- Write 0x18, 0x12, then STOP → VCM_DATA unchanged and no DATA_VALID. Next, write 0x18, 0x12, repeated START, 0x19, read two bytes → the read returns the old VCM_DATA.
- With VCM_DATA=16'hA55A: read 0x19, master ACK, ACK, NACK → bytes returned are 0xA5, 0x5A, 0xA5; then IDLE.
- Write three data bytes 0x01, 0x02, 0x03 → third byte NACKed; VCM_DATA=16'h0102.
- 2-cycle SDA glitch while SCL is high → no START/STOP detected. Assert RESET during a read bit → SDA_OE=0 in the same cycle, and all outputs return to their reset values.

Source files
------------

// File: rtl/vcm_i2c_pkg.sv
// Shared definitions for the VCM focus-driver I2C target and its master-side controller.
package vcm_i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck
    } state_e;

    localparam logic [6:0] VCM_ADDR_DEFAULT = 7'h0C;

    // DAC position field inside the 16-bit focus word
    localparam int unsigned STEP_MSB = 13;
    localparam int unsigned STEP_LSB = 4;
    localparam int unsigned STEP_W   = STEP_MSB - STEP_LSB + 1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one I2C line.
// The output only takes a new level after it has been stable for FILT cycles.
module i2c_line_filter #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = 3;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pad level into the clock domain; idle bus is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a differing level once it has persisted for FILT consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 1'b1;
            cnt  <= '0;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT - 1)) begin
            dout <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vcm_i2c_target.sv
// I2C target modelling the VCM focus driver: 2-byte focus writes, wrapping 2-byte reads.
module vcm_i2c_target
    import vcm_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = VCM_ADDR_DEFAULT,
    parameter int unsigned FILT     = 3
) (
    input  logic              CLK_50,
    input  logic              RESET,
    input  logic              SCL,
    input  logic              SDA_IN,
    output logic              SDA_OE,
    output logic [15:0]       VCM_DATA,
    output logic [STEP_W-1:0] STEP,
    output logic              DATA_VALID,
    output logic              BUSY
);

    logic scl_f, sda_f, scl_q, sda_q;
    logic start, stop, scl_rise, scl_fall;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d, tx_q, tx_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d, vcm_q, vcm_d;
    logic        nack_q, nack_d, sda_oe_q, sda_oe_d;
    logic        valid_q, valid_d, busy_q, busy_d;
    logic        addr_match;
    logic [7:0]  rd_first, rd_next;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk  (CLK_50),
        .rst  (RESET),
        .din  (SCL),
        .dout (scl_f)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk  (CLK_50),
        .rst  (RESET),
        .din  (SDA_IN),
        .dout (sda_f)
    );

    // Previous filtered levels for edge and bus-condition detection.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign start    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop     = scl_f & scl_q & ~sda_q & sda_f;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;

    assign addr_match = (rx_q[7:1] == DEV_ADDR);
    // Byte for the current read index, and the one after the 1->0 wrap.
    assign rd_first   = idx_q[0] ? vcm_q[7:0]  : vcm_q[15:8];
    assign rd_next    = idx_q[0] ? vcm_q[15:8] : vcm_q[7:0];

    // FSM state register.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state; bus conditions override every state.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else if (start) begin
            state_d = StAddr;
        end else begin
            case (state_q)
                StAddr:    if (scl_fall && bit_cnt_q == 4'd8)
                               state_d = addr_match ? StAddrAck : StIdle;
                StAddrAck: if (scl_fall) state_d = rx_q[0] ? StRdByte : StWrByte;
                StWrByte:  if (scl_fall && bit_cnt_q == 4'd8) state_d = StWrAck;
                StWrAck:   if (scl_fall) state_d = StWrByte;
                StRdByte:  if (scl_fall && bit_cnt_q == 4'd8) state_d = StRdAck;
                StRdAck:   if (scl_fall) state_d = nack_q ? StIdle : StRdByte;
                default:   state_d = state_q;
            endcase
        end
    end

    // Datapath and outputs; SDA drive only moves on a detected SCL fall.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        nack_d    = nack_q;
        sda_oe_d  = sda_oe_q;
        vcm_d     = vcm_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        if (stop) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            idx_d     = '0;
        end else if (start) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            idx_d     = '0;
        end else begin
            case (state_q)
                StAddr, StWrByte: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            sda_oe_d = addr_match;
                            busy_d   = addr_match;
                        end else begin
                            sda_oe_d = (idx_q < 2'd2);
                            if (idx_q == 2'd0)      shadow_d[15:8] = rx_q;
                            else if (idx_q == 2'd1) shadow_d[7:0]  = rx_q;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        tx_d     = rd_first;
                        sda_oe_d = rx_q[0] ? ~rd_first[7] : 1'b0;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (idx_q == 2'd1) begin
                            vcm_d   = shadow_q;
                            valid_d = 1'b1;
                        end
                        if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
                    end
                end
                StRdByte: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) nack_d = sda_f;
                    if (scl_fall && !nack_q) begin
                        idx_d    = {1'b0, ~idx_q[0]};
                        tx_d     = rd_next;
                        sda_oe_d = ~rd_next[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; SDA_OE releases the instant RESET asserts.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            nack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            vcm_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            nack_q    <= nack_d;
            sda_oe_q  <= sda_oe_d;
            vcm_q     <= vcm_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign SDA_OE     = sda_oe_q;
    assign VCM_DATA   = vcm_q;
    assign STEP       = vcm_q[STEP_MSB:STEP_LSB];
    assign DATA_VALID = valid_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_vcm_i2c_target.sv
// Bench for vcm_i2c_target: bit-level I2C master plus a transaction-level model of the target.
module tb_vcm_i2c_target;

    localparam int Q = 10;  // quarter SCL period in CLK_50 cycles

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, dv, busy;
    logic [15:0] vcm;
    logic [9:0]  step;
    wire        sda_pad = sda_oe ? 1'b0 : sda_m;

    always #10 clk = ~clk;

    vcm_i2c_target #(.DEV_ADDR(7'h0C), .FILT(3)) dut (
        .CLK_50     (clk),
        .RESET      (rst),
        .SCL        (scl),
        .SDA_IN     (sda_pad),
        .SDA_OE     (sda_oe),
        .VCM_DATA   (vcm),
        .STEP       (step),
        .DATA_VALID (dv),
        .BUSY       (busy)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pulse = 0;
    logic [15:0] exp_vcm = 16'h0;
    logic [15:0] pend_val = 16'h0;
    bit          pend_valid = 1'b0;
    bit          quiet = 1'b0;
    logic [7:0]  rd_got [4];
    logic        a;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Per-cycle check of committed focus word, STEP and DATA_VALID against the model.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_vcm    = 16'h0;
                pend_valid = 1'b0;
            end else begin
                if (dv) begin
                    n_pulse++;
                    if (pend_valid) begin
                        chk("commit_vcm", vcm, pend_val);
                        exp_vcm    = pend_val;
                        pend_valid = 1'b0;
                    end else begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_dv: got DATA_VALID=1 want 0");
                    end
                end else begin
                    chk("vcm_hold", vcm, exp_vcm);
                end
                chk("step", step, exp_vcm[13:4]);
                if (quiet) begin
                    chk("quiet_oe", sda_oe, 0);
                    chk("quiet_busy", busy, 0);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        idle(Q); sda_m = 1'b1; idle(Q); scl = 1'b1; idle(2*Q); sda_m = 1'b0; idle(2*Q); scl = 1'b0;
    endtask

    task automatic bus_stop();
        idle(Q); sda_m = 1'b0; idle(Q); scl = 1'b1; idle(2*Q); sda_m = 1'b1; idle(2*Q);
    endtask

    task automatic bit_io(input logic b, output logic s);
        idle(Q); sda_m = b; idle(Q); scl = 1'b1; idle(Q); s = sda_pad; idle(Q); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            b[i] = s;
        end
        bit_io(~mack, s);
    endtask

    // Model: only address 0x0C/W is ACKed; data bytes 0 and 1 ACKed; byte 1 commits.
    task automatic write_txn(input logic [7:0] addr, input int n, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] d2, input bit do_stop);
        logic       ack;
        logic [7:0] d [3];
        bit         hit;
        d[0] = d0; d[1] = d1; d[2] = d2;
        hit = (addr == 8'h18);
        bus_start();
        send_byte(addr, ack);
        chk("addr_ack", ack, hit);
        if (hit) chk("busy_after_match", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (hit && i == 1) begin
                pend_val   = {d[0], d[1]};
                pend_valid = 1'b1;
            end
            send_byte(d[i], ack);
            chk("data_ack", ack, hit && i < 2);
        end
        if (do_stop) begin
            bus_stop();
            chk("busy_after_stop", busy, 0);
            chk("commit_seen", pend_valid, 0);
        end
    endtask

    // Model: read index starts at 0 and alternates high byte / low byte.
    task automatic read_txn(input int n, input bit do_stop);
        logic       ack;
        logic [7:0] b;
        bus_start();
        send_byte(8'h19, ack);
        chk("rd_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            chk("rd_data", b, (i % 2 == 0) ? exp_vcm[15:8] : exp_vcm[7:0]);
            rd_got[i] = b;
        end
        if (do_stop) bus_stop();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oe"}, sda_oe, 0);
        chk({tag, "_vcm"}, vcm, 16'h0000);
        chk({tag, "_step"}, step, 10'h000);
        chk({tag, "_dv"}, dv, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        idle(5);
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        idle(5);
        chk_reset_vals("rst_rel");

        // Full 2-byte write
        write_txn(8'h18, 2, 8'h3F, 8'hF0, 8'h00, 1'b1);
        chk("t1_vcm", vcm, 16'h3FF0);
        chk("t1_step", step, 10'h3FF);
        chk("t1_pulses", n_pulse, 1);

        // Wrong address: target must stay off the bus
        quiet = 1'b1;
        write_txn(8'h1A, 2, 8'h55, 8'hAA, 8'h00, 1'b1);
        quiet = 1'b0;
        chk("t2_vcm", vcm, 16'h3FF0);

        // Single byte then STOP is discarded
        write_txn(8'h18, 1, 8'h12, 8'h00, 8'h00, 1'b1);
        chk("t3_pulses", n_pulse, 1);
        // Single byte then repeated START into a read
        write_txn(8'h18, 1, 8'h12, 8'h00, 8'h00, 1'b0);
        read_txn(2, 1'b1);
        chk("t3_rd0", rd_got[0], 8'h3F);
        chk("t3_rd1", rd_got[1], 8'hF0);
        chk("t3_pulses_b", n_pulse, 1);

        // Wrapping read
        write_txn(8'h18, 2, 8'hA5, 8'h5A, 8'h00, 1'b1);
        read_txn(3, 1'b1);
        chk("t4_rd0", rd_got[0], 8'hA5);
        chk("t4_rd1", rd_got[1], 8'h5A);
        chk("t4_rd2", rd_got[2], 8'hA5);
        chk("t4_busy", busy, 0);

        // Third data byte NACKed and ignored
        write_txn(8'h18, 3, 8'h01, 8'h02, 8'h03, 1'b1);
        chk("t5_vcm", vcm, 16'h0102);
        chk("t5_pulses", n_pulse, 3);

        // 2-cycle SDA glitch with SCL high must not register as START
        idle(2*Q);
        sda_m = 1'b0;
        idle(2);
        sda_m = 1'b1;
        idle(2*Q);
        quiet = 1'b1;
        send_byte(8'h18, a);
        chk("glitch_no_ack", a, 0);
        bus_stop();
        quiet = 1'b0;
        chk("glitch_vcm", vcm, 16'h0102);

        // RESET while the target drives a read bit (byte 0x01, bit 7 = 0)
        bus_start();
        send_byte(8'h19, a);
        chk("t7_addr_ack", a, 1);
        idle(Q); sda_m = 1'b1; idle(Q); scl = 1'b1; idle(Q);
        chk("t7_drive", sda_oe, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("t7_oe_async", sda_oe, 0);
        chk_reset_vals("t7_in_rst");
        idle(5);
        rst = 1'b0;
        idle(20);
        chk_reset_vals("t7_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
